march_bist_ctrl: RTL
====================

// Module: march_bist_ctrl
// PURPOSE
//  March C- BIST controller for the single-port synchronous memory block.
//  Drives the memory's read/write/address/data_in ports directly and checks data_out.
//  Reports done/fail and captures the first failure.
//  Sits between the test-mode mux and the memory; the functional path is muxed in outside this block.
// PARAMETERS
//  a_width  4  memory address width
//  width    4  memory data width
//  depth    4  words under test, addresses 0..depth-1; 1 <= depth <= 2**a_width
// PORTS
//  clk           in   1        rising-edge clock
//  rst           in   1        synchronous, active-low reset
//  start         in   1        begin test; sampled only in IDLE or DONE
//  mem_read      out  1        memory read strobe
//  mem_write     out  1        memory write strobe
//  mem_addr      out  a_width  memory address
//  mem_wdata     out  width    memory write data
//  mem_rdata     in   width    memory data_out; registered, valid 1 cycle after mem_read
//  busy          out  1        high in RUN and DRAIN
//  done          out  1        high in DONE until the next start
//  fail          out  1        sticky; set on any miscompare in the current run
//  fail_element  out  3        March element (0..5) of the first miscompare
//  fail_addr     out  a_width  address of the first miscompare
//  fail_data     out  width    mem_rdata captured at the first miscompare
// BEHAVIOUR
//  Reset (rst==0 at a clock edge): state=IDLE; all outputs 0, including mem_read and mem_write.
//   Reset mid-run aborts immediately; no partial status is kept.
//  March C- elements, one memory operation per clock:
//   M0 up(w0)  M1 up(r0,w1)  M2 up(r1,w0)  M3 down(r0,w1)  M4 down(r1,w0)  M5 up(r0)
//   0 = all-zeros word, 1 = all-ones word ({width{1'b1}}).
//  Op cycles: 10*depth. Up order is 0..depth-1; down order is depth-1..0.
//   Within an element the address changes only after the element's last op at that address.
//  mem_read and mem_write are never high together. Both are low in IDLE, DRAIN and DONE.
//   mem_wdata is 0 on non-write cycles.
//  Compare pipeline: a read issued in cycle t is compared in cycle t+1 against expected
//   value, element and address registered at t. Writes do not disturb mem_rdata.
//  FSM states:
//   IDLE  -> RUN    on start
//   RUN   -> DRAIN  after the last M5 read is issued
//   DRAIN -> DONE   unconditionally; DRAIN performs the final compare
//   DONE  -> RUN    on start; clears fail and fail_* in the same edge
//  Latency: start sampled at edge N; first op at cycle N+1; done=1 from cycle N+10*depth+2.
//  start while busy is ignored. start held high in DONE restarts every pass.
//  First-fail capture: on the first miscompare, fail_element, fail_addr and fail_data load once.
//   Later miscompares only keep fail=1. The test always runs to completion.
//  Counters: element 3b, op-in-element 1b, address a_width bits.
//   The address counter saturates at its end-of-element value; it never wraps.
//   Up direction ends at depth-1; down direction ends at 0.
// STRUCTURE
//  bist_pkg: state enum (IDLE, RUN, DRAIN, DONE); element indices M0..M5;
//   per-element tables for direction, op count, op kind and data background.
//  Sub-module march_addr_gen: loadable up/down address counter.
//   Outputs addr and last (end-of-element); instantiated once.
//  Top level holds the FSM, element/op counters, the compare pipeline and the fail capture.
// TESTING
//  T1 fault-free, depth=4: start at N ->
//   busy N+1..N+41; done at N+42; fail=0; exactly 40 op cycles.
//   Addresses ascend 0..3 in M0-M2 and M5; descend 3..0 in M3-M4.
//  T2 bit0 of addr 2 stuck-at-1 in the memory model ->
//   fail=1, fail_element=1, fail_addr=2, fail_data=4'b0001; done still at N+42.
//  T3 rst=0 at N+15 -> after the next edge, all outputs are 0 and the state is IDLE.
//   A restart then completes fault-free at +42.
//  T4 start pulses at N+5 (busy) have no effect.
//   start in DONE -> done=0 next cycle, fail cleared, new 40-op pass.
//  T5 protocol checker, every cycle: !(mem_read && mem_write); mem_wdata in {4'h0, 4'hF};
//   write data is 4'h0 in M0/M2/M4 and 4'hF in M1/M3.
//  T6 depth=1 -> 10 ops, all at addr 0; done at N+12; no address over- or underflow.

Source files
------------

// File: rtl/march_bist_ctrl_pkg.sv
// march_bist_ctrl_pkg: FSM states, March C- element indices and per-element operation tables
package march_bist_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_t;

    // Bit e of each table describes element Me; bits 6 and 7 are never addressed
    localparam logic [7:0] elem_down_tbl = 8'b0001_1000;
    localparam logic [7:0] elem_two_tbl  = 8'b0001_1110;
    localparam logic [7:0] bg_op0_tbl    = 8'b0001_0100;
    localparam logic [7:0] bg_op1_tbl    = 8'b0000_1010;

    function automatic logic is_down(elem_t e);
        return elem_down_tbl[e];
    endfunction

    function automatic logic last_op_of(elem_t e);
        return elem_two_tbl[e];
    endfunction

    function automatic logic op_read(elem_t e, logic op);
        return e != M0 && !op;
    endfunction

    function automatic logic op_bit(elem_t e, logic op);
        return op ? bg_op1_tbl[e] : bg_op0_tbl[e];
    endfunction

endpackage

// File: rtl/march_bist_ctrl_if.sv
// march_bist_ctrl_if: single-port memory bus between the BIST controller and the memory under test
interface march_bist_ctrl_if #(
    parameter int a_width = 4,
    parameter int width   = 4
);
    logic               mem_read;
    logic               mem_write;
    logic [a_width-1:0] mem_addr;
    logic [width-1:0]   mem_wdata;
    logic [width-1:0]   mem_rdata;

    modport master(output mem_read, mem_write, mem_addr, mem_wdata, input mem_rdata);
    modport slave(input mem_read, mem_write, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/march_bist_ctrl_addr_gen.sv
// march_bist_ctrl_addr_gen: loadable up/down address counter that saturates at its end-of-element value
module march_bist_ctrl_addr_gen #(
    parameter int a_width = 4,
    parameter int depth   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               load_down,
    input  logic               step,
    output logic [a_width-1:0] addr,
    output logic               last
);
    localparam logic [a_width-1:0] top = a_width'(depth - 1);

    logic down;

    assign last = down ? addr == '0 : addr == top;

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr <= '0;
            down <= 1'b0;
        end else if (load) begin
            addr <= load_down ? top : '0;
            down <= load_down;
        end else if (step && !last) begin
            addr <= down ? addr - a_width'(1) : addr + a_width'(1);
        end
    end
endmodule

// File: rtl/march_bist_ctrl.sv
// march_bist_ctrl: March C- BIST sequencer with a one-cycle read compare and first-fail capture
module march_bist_ctrl
    import march_bist_ctrl_pkg::*;
#(
    parameter int a_width = 4,
    parameter int width   = 4,
    parameter int depth   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    march_bist_ctrl_if.master  mem,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [2:0]         fail_element,
    output logic [a_width-1:0] fail_addr,
    output logic [width-1:0]   fail_data
);
    state_t             state, state_n;
    elem_t              elem, elem_n, cmp_elem;
    logic               op, op_n;
    logic               start_ok, run, last_op, a_last, adv_elem, run_end, go;
    logic               nxt_rd, nxt_bit;
    logic               rd, wr, cmp_v, miss;
    logic [a_width-1:0] addr, cmp_addr;
    logic [width-1:0]   wdata, cmp_exp;

    assign start_ok = (state == IDLE || state == DONE) && start;
    assign run      = state == RUN;
    assign last_op  = op == last_op_of(elem);
    assign adv_elem = run && last_op && a_last && elem != M5;
    assign run_end  = run && last_op && a_last && elem == M5;
    assign go       = start_ok || (run && !run_end);
    assign elem_n   = start_ok ? M0 : adv_elem ? elem_t'(elem + 3'd1) : elem;
    assign op_n     = !start_ok && !last_op;
    assign nxt_rd   = op_read(elem_n, op_n);
    assign nxt_bit  = op_bit(elem_n, op_n);
    assign miss     = cmp_v && mem.mem_rdata != cmp_exp;

    always_comb begin
        state_n = start_ok ? RUN : run_end ? DRAIN : state == DRAIN ? DONE : state;
    end

    march_bist_ctrl_addr_gen #(.a_width(a_width), .depth(depth)) u_addr (
        .clk      (clk),
        .rst      (rst),
        .load     (start_ok || adv_elem),
        .load_down(is_down(elem_n)),
        .step     (run && last_op && !a_last),
        .addr     (addr),
        .last     (a_last)
    );

    // Output registers describe the op in flight; compare registers trail them by one cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            elem         <= M0;
            op           <= 1'b0;
            rd           <= 1'b0;
            wr           <= 1'b0;
            wdata        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cmp_v        <= 1'b0;
            cmp_exp      <= '0;
            cmp_elem     <= M0;
            cmp_addr     <= '0;
            fail         <= 1'b0;
            fail_element <= '0;
            fail_addr    <= '0;
            fail_data    <= '0;
        end else begin
            state    <= state_n;
            if (go) begin
                elem <= elem_n;
                op   <= op_n;
            end
            rd       <= go && nxt_rd;
            wr       <= go && !nxt_rd;
            wdata    <= go && !nxt_rd ? {width{nxt_bit}} : '0;
            busy     <= state_n == RUN || state_n == DRAIN;
            done     <= state_n == DONE;
            cmp_v    <= rd;
            cmp_exp  <= {width{op_bit(elem, op)}};
            cmp_elem <= elem;
            cmp_addr <= addr;
            if (start_ok) begin
                fail         <= 1'b0;
                fail_element <= '0;
                fail_addr    <= '0;
                fail_data    <= '0;
            end else if (miss) begin
                fail <= 1'b1;
                if (!fail) begin
                    fail_element <= cmp_elem;
                    fail_addr    <= cmp_addr;
                    fail_data    <= mem.mem_rdata;
                end
            end
        end
    end

    assign mem.mem_read  = rd;
    assign mem.mem_write = wr;
    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = wdata;
endmodule
